// File: rtl/ro_scan_meter_if.sv
// Result handshake between the ring-oscillator scan meter and its consumer.
// The meter drives the master side, the UART/controller side uses the slave side.
interface ro_scan_meter_if #(
  parameter int CNT_W = 16,
  parameter int CH_W  = 2
);
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_data;
  logic [CH_W-1:0]  res_ch;
  logic             res_dead;

  modport master (output res_valid, output res_data, output res_ch, output res_dead,
                  input  res_ready);
  modport slave  (input  res_valid, input  res_data, input  res_ch, input  res_dead,
                  output res_ready);
endinterface

// File: rtl/ro_scan_meter.sv
// Round-robin ring-oscillator meter: enables one channel at a time, counts its edges
// over averaged gate windows and hands each result out on a valid/ready handshake.
module ro_scan_meter #(
  parameter int NCH        = 4,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int AVG_LOG2   = 3,
  parameter int SETTLE_CYC = 16,
  parameter int CH_W       = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   osc_in,
  output logic [NCH-1:0]   osc_en,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             start,
  input  logic             continuous,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  ro_scan_meter_if.master  res_if
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int IDX_W = AVG_LOG2 + 1;
  localparam int ST_W  = $clog2(SETTLE_CYC);
  localparam logic [IDX_W-1:0] N_WIN      = IDX_W'(2 ** AVG_LOG2);
  localparam logic [ST_W-1:0]  SETTLE_END = ST_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_OUTPUT  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [NCH-1:0]   sync1_q, sync2_q, prev_q;
  logic [NCH-1:0]   scan_mask_q, scan_mask_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [ST_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;
  logic             zero_all_q, zero_all_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [NCH-1:0]   osc_en_q, osc_en_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] res_data_q, res_data_d;
  logic [CH_W-1:0]  res_ch_q, res_ch_d;
  logic             res_dead_q, res_dead_d;

  logic [NCH-1:0]   edge_s;
  logic [ACC_W-1:0] acc_sum_s;
  logic [WIN_W-1:0] win_last_s;
  logic [CH_W:0]    next_s;

  function automatic logic [CH_W-1:0] lowest_bit(input logic [NCH-1:0] m);
    lowest_bit = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = CH_W'(i);
    end
  endfunction

  // {found, index} of the lowest mask bit strictly above cur
  function automatic logic [CH_W:0] next_above(input logic [NCH-1:0] m, input logic [CH_W-1:0] cur);
    next_above = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) next_above = {1'b1, CH_W'(i)};
    end
  endfunction

  assign edge_s     = sync2_q & ~prev_q;
  assign acc_sum_s  = acc_q + ACC_W'(cnt_q);
  assign win_last_s = (win_len_q == '0) ? '0 : win_len_q - WIN_W'(1);
  assign next_s     = next_above(scan_mask_q, ch_q);

  always_comb begin
    state_d      = state_q;
    scan_mask_d  = scan_mask_q;
    win_len_d    = win_len_q;
    win_cnt_d    = win_cnt_q;
    settle_cnt_d = settle_cnt_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    win_idx_d    = win_idx_q;
    zero_all_d   = zero_all_q;
    ch_d         = ch_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_ch_d     = res_ch_q;
    res_dead_d   = res_dead_q;
    osc_en_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (start && (ch_mask != '0)) begin
          scan_mask_d  = ch_mask;
          win_len_d    = win_len;
          ch_d         = lowest_bit(ch_mask);
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        cnt_d      = '0;
        acc_d      = '0;
        win_idx_d  = '0;
        zero_all_d = 1'b1;
        win_cnt_d  = '0;
        if (settle_cnt_q == SETTLE_END) begin
          state_d = ST_MEASURE;
        end else begin
          settle_cnt_d = settle_cnt_q + ST_W'(1);
        end
      end
      ST_MEASURE: begin
        if (edge_s[ch_q] && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (win_cnt_q == win_last_s) begin
          state_d = ST_ACCUM;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end
      ST_ACCUM: begin
        acc_d      = acc_sum_s;
        zero_all_d = zero_all_q & (cnt_q == '0);
        cnt_d      = '0;
        win_idx_d  = win_idx_q + IDX_W'(1);
        win_cnt_d  = '0;
        if (win_idx_d == N_WIN) begin
          res_valid_d = 1'b1;
          res_data_d  = acc_sum_s[ACC_W-1:AVG_LOG2];
          res_ch_d    = ch_q;
          res_dead_d  = zero_all_d;
          state_d     = ST_OUTPUT;
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_OUTPUT: begin
        if (res_valid_q && res_if.res_ready) begin
          res_valid_d  = 1'b0;
          settle_cnt_d = '0;
          if (next_s[CH_W]) begin
            ch_d    = next_s[CH_W-1:0];
            state_d = ST_SETTLE;
          end else if (continuous && (ch_mask != '0)) begin
            scan_mask_d = ch_mask;
            win_len_d   = win_len;
            ch_d        = lowest_bit(ch_mask);
            state_d     = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    if ((state_d == ST_SETTLE) || (state_d == ST_MEASURE) || (state_d == ST_ACCUM)) begin
      osc_en_d[ch_d] = 1'b1;
    end else begin
      osc_en_d = '0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // osc_in is asynchronous: two flops to resolve metastability, a third for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= osc_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      scan_mask_q  <= '0;
      win_len_q    <= '0;
      win_cnt_q    <= '0;
      settle_cnt_q <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      win_idx_q    <= '0;
      zero_all_q   <= 1'b0;
      ch_q         <= '0;
      osc_en_q     <= '0;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_ch_q     <= '0;
      res_dead_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_mask_q  <= scan_mask_d;
      win_len_q    <= win_len_d;
      win_cnt_q    <= win_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      win_idx_q    <= win_idx_d;
      zero_all_q   <= zero_all_d;
      ch_q         <= ch_d;
      osc_en_q     <= osc_en_d;
      busy_q       <= busy_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_ch_q     <= res_ch_d;
      res_dead_q   <= res_dead_d;
    end
  end

  assign osc_en           = osc_en_q;
  assign busy             = busy_q;
  assign res_if.res_valid = res_valid_q;
  assign res_if.res_data  = res_data_q;
  assign res_if.res_ch    = res_ch_q;
  assign res_if.res_dead  = res_dead_q;

endmodule

// File: tb/tb_ro_scan_meter.sv
// Bench for ro_scan_meter: square-wave oscillators with random phase/period, expected
// results derived from edges-per-window arithmetic and the scan-order rules.
module tb_ro_scan_meter;

  localparam int SETTLE = 16;
  localparam int NWIN   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  osc_in;
  logic [3:0]  osc_en;
  logic [3:0]  ch_mask;
  logic        start;
  logic        continuous;
  logic [15:0] win_len;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int per[4];
  int ph[4];

  ro_scan_meter_if #(.CNT_W(16), .CH_W(2)) rif ();

  ro_scan_meter #(
    .NCH(4), .CNT_W(16), .WIN_W(16), .AVG_LOG2(3), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .reset(reset), .osc_in(osc_in), .osc_en(osc_en), .ch_mask(ch_mask),
    .start(start), .continuous(continuous), .win_len(win_len), .busy(busy), .res_if(rif)
  );

  always #5 clk = ~clk;

  // Oscillator model: period per[i] clk cycles, high for the second half; 0 = stuck low
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (per[i] == 0) begin
        osc_in[i] = 1'b0;
      end else begin
        ph[i]     = (ph[i] + 1) % per[i];
        osc_in[i] = (ph[i] >= per[i] / 2);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_osc(input int p0, input int p1, input int p2, input int p3);
    per[0] = p0; per[1] = p1; per[2] = p2; per[3] = p3;
    for (int i = 0; i < 4; i++) ph[i] = (per[i] > 0) ? int'($urandom_range(0, per[i] - 1)) : 0;
  endtask

  task automatic start_scan(input logic [3:0] m, input logic [15:0] w, input logic c);
    ch_mask = m; win_len = w; continuous = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic int latency(input int w);
    return SETTLE + NWIN * (((w == 0) ? 1 : w) + 1);
  endfunction

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while ((rif.res_valid !== 1'b1) && (n < budget)) begin
      tick();
      n++;
    end
    check("valid_seen", {31'b0, rif.res_valid}, 32'd1);
  endtask

  // Wait for a result, compare it, optionally stall for hold cycles, then transfer
  task automatic take(input string tag, input int exp_data, input int exp_ch,
                      input logic exp_dead, input int hold);
    int n;
    wait_valid(latency(int'(win_len)) + 40, n);
    check({tag, "_data"}, 32'(rif.res_data), 32'(exp_data));
    check({tag, "_ch"},   32'(rif.res_ch),   32'(exp_ch));
    check({tag, "_dead"}, {31'b0, rif.res_dead}, {31'b0, exp_dead});
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold_valid"}, {31'b0, rif.res_valid}, 32'd1);
      check({tag, "_hold_data"}, 32'(rif.res_data), 32'(exp_data));
      check({tag, "_hold_ch"},   32'(rif.res_ch),   32'(exp_ch));
      check({tag, "_hold_osc"},  32'(osc_en),       32'd0);
    end
    rif.res_ready = 1'b1;
    tick();
    rif.res_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'b0, rif.res_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int plist[5] = '{4, 6, 8, 10, 12};
    logic [3:0] m;
    int q_ch[$];

    reset = 1'b1; ch_mask = 4'b0000; start = 1'b0; continuous = 1'b0; win_len = 16'd0;
    rif.res_ready = 1'b0;
    set_osc(0, 0, 0, 0);
    tick(); tick();
    check("rst_osc_en", 32'(osc_en), 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, rif.res_valid}, 32'd0);
    check("rst_data", 32'(rif.res_data), 32'd0);
    reset = 1'b0;
    tick();

    // Single channel, latency and value
    set_osc(0, 4, 0, 0);
    start_scan(4'b0010, 16'd100, 1'b0);
    check("t1_busy", {31'b0, busy}, 32'd1);
    check("t1_osc_en", 32'(osc_en), 32'b0010);
    wait_valid(900, n);
    check("t1_latency", 32'(n), 32'(latency(100)));
    take("t1", 25, 1, 1'b0, 0);
    check("t1_busy_end", {31'b0, busy}, 32'd0);
    check("t1_osc_end", 32'(osc_en), 32'd0);

    // Three channels with a 50-cycle stall on ch1
    set_osc(4, 8, 0, 10);
    start_scan(4'b1011, 16'd200, 1'b0);
    take("t2_c0", 50, 0, 1'b0, 0);
    take("t2_c1", 25, 1, 1'b0, 50);
    take("t2_c3", 20, 3, 1'b0, 0);
    check("t2_busy_end", {31'b0, busy}, 32'd0);
    check("t2_osc_end", 32'(osc_en), 32'd0);

    // Random masks/periods; window 120 is a multiple of every period so counts are exact
    for (int it = 0; it < 3; it++) begin
      m = 4'($urandom_range(1, 15));
      set_osc(plist[$urandom_range(0, 4)], plist[$urandom_range(0, 4)],
              plist[$urandom_range(0, 4)], plist[$urandom_range(0, 4)]);
      q_ch.delete();
      for (int c = 0; c < 4; c++) if (m[c]) q_ch.push_back(c);
      start_scan(m, 16'd120, 1'b0);
      while (q_ch.size() > 0) begin
        int c;
        c = q_ch.pop_front();
        take("rnd", 120 / per[c], c, 1'b0, 0);
      end
      check("rnd_busy_end", {31'b0, busy}, 32'd0);
    end

    // Dead oscillator in continuous mode, then mask cleared
    set_osc(0, 0, 0, 0);
    start_scan(4'b0100, 16'd10, 1'b1);
    take("dead1", 0, 2, 1'b1, 0);
    check("dead_busy_cont", {31'b0, busy}, 32'd1);
    take("dead2", 0, 2, 1'b1, 0);
    ch_mask = 4'b0000;
    take("dead3", 0, 2, 1'b1, 0);
    check("dead_idle", {31'b0, busy}, 32'd0);
    continuous = 1'b0;

    // Reset during MEASURE of ch1
    set_osc(4, 8, 0, 10);
    start_scan(4'b0011, 16'd20, 1'b0);
    take("r1_c0", 5, 0, 1'b0, 0);
    for (int k = 0; k < SETTLE + 30; k++) tick();
    check("r1_osc_pre", 32'(osc_en), 32'b0010);
    reset = 1'b1;
    #1;
    check("r1_osc_en", 32'(osc_en), 32'd0);
    check("r1_busy", {31'b0, busy}, 32'd0);
    check("r1_valid", {31'b0, rif.res_valid}, 32'd0);
    tick();
    reset = 1'b0;
    start_scan(4'b1011, 16'd120, 1'b0);
    take("r1_a0", 30, 0, 1'b0, 0);
    take("r1_a1", 15, 1, 1'b0, 0);
    take("r1_a3", 12, 3, 1'b0, 0);

    // Reset while a result is pending
    start_scan(4'b0010, 16'd20, 1'b0);
    wait_valid(latency(20) + 40, n);
    reset = 1'b1;
    #1;
    check("r2_valid", {31'b0, rif.res_valid}, 32'd0);
    check("r2_busy", {31'b0, busy}, 32'd0);
    check("r2_osc_en", 32'(osc_en), 32'd0);
    check("r2_data", 32'(rif.res_data), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Start with an empty mask is ignored
    start_scan(4'b0000, 16'd20, 1'b0);
    tick();
    check("m0_busy", {31'b0, busy}, 32'd0);
    check("m0_osc_en", 32'(osc_en), 32'd0);

    // win_len=0 gives one-cycle windows
    set_osc(2, 0, 0, 0);
    start_scan(4'b0001, 16'd0, 1'b0);
    wait_valid(latency(0) + 40, n);
    check("w0_latency", 32'(n), 32'(latency(0)));
    check("w0_range", {31'b0, (rif.res_data <= 16'd1)}, 32'd1);
    check("w0_ch", 32'(rif.res_ch), 32'd0);
    rif.res_ready = 1'b1;
    tick();
    rif.res_ready = 1'b0;
    check("w0_busy_end", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
